// File: rtl/pedestrian_signal.sv
// Pedestrian WALK / DONT_WALK controller slaved to the vehicle red phase.
// Optional conflict monitor enabled by defining PED_CONFLICT_MONITOR_EN.
module pedestrian_signal #(
   parameter int unsigned WALK_CYCLES  = 16,
   parameter int unsigned FLASH_CYCLES = 8,
   parameter int unsigned BLINK_HALF   = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic red,
   input  logic yellow,
   input  logic green,
   input  logic ped_button,
   output logic walk,
   output logic dont_walk,
   output logic req_pending,
   output logic fault
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_HALF - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_FLASH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_blink_cnt;
   logic [CNT_W-1:0] w_blink_cnt_nxt;
   logic             r_phase;
   logic             w_phase_nxt;
   logic             r_red_q;
   logic             w_red_rise;
   logic             w_abort;
   logic             w_go_walk;
   logic             r_req;
   logic             w_req_nxt;
   logic             r_fault;
   logic             w_fault_nxt;
   logic             r_walk;
   logic             w_walk_nxt;
   logic             r_dont_walk;
   logic             w_dont_walk_nxt;

`ifndef PED_CONFLICT_MONITOR_EN
   // Vehicle green/yellow only matter to the conflict monitor.
   logic w_unused_lamps;
   assign w_unused_lamps = yellow ^ green;
`endif

   // Next-state, counter and registered-output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_blink_cnt_nxt = r_blink_cnt;
      w_phase_nxt     = r_phase;
      w_go_walk       = 1'b0;
      w_red_rise      = red & ~r_red_q;
      w_fault_nxt     = r_fault;
      w_abort         = (r_state != ST_IDLE) && !red;
`ifdef PED_CONFLICT_MONITOR_EN
      if (red && green) begin
         w_fault_nxt = 1'b1;
      end
      if ((r_state != ST_IDLE) && (green || yellow)) begin
         w_abort     = 1'b1;
         w_fault_nxt = 1'b1;
      end
`endif

      case (r_state)
         ST_IDLE: begin
            if (enable && w_red_rise && (r_req || ped_button) && !w_fault_nxt) begin
               w_go_walk   = 1'b1;
               w_state_nxt = ST_WALK;
               w_cnt_nxt   = WALK_LOAD;
            end
         end
         ST_WALK: begin
            if (w_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (enable) begin
               if (r_cnt == '0) begin
                  w_state_nxt     = ST_FLASH;
                  w_cnt_nxt       = FLASH_LOAD;
                  w_blink_cnt_nxt = BLINK_LOAD;
                  w_phase_nxt     = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
         end
         ST_FLASH: begin
            if (w_abort) begin
               w_state_nxt = ST_IDLE;
            end else if (enable) begin
               if (r_blink_cnt == '0) begin
                  w_blink_cnt_nxt = BLINK_LOAD;
                  w_phase_nxt     = ~r_phase;
               end else begin
                  w_blink_cnt_nxt = r_blink_cnt - CNT_W'(1);
               end
               if (r_cnt == '0) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Entering WALK consumes the request, even against a same-cycle press.
      w_req_nxt       = w_go_walk ? 1'b0 : (r_req | ped_button);
      w_walk_nxt      = (w_state_nxt == ST_WALK);
      w_dont_walk_nxt = (w_state_nxt == ST_IDLE) || ((w_state_nxt == ST_FLASH) && w_phase_nxt);
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_red_q     <= 1'b0;
         r_req       <= 1'b0;
         r_fault     <= 1'b0;
         r_walk      <= 1'b0;
         r_dont_walk <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_phase     <= w_phase_nxt;
         r_red_q     <= red;
         r_req       <= w_req_nxt;
         r_fault     <= w_fault_nxt;
         r_walk      <= w_walk_nxt;
         r_dont_walk <= w_dont_walk_nxt;
      end
   end

   assign walk        = r_walk;
   assign dont_walk   = r_dont_walk;
   assign req_pending = r_req;
   assign fault       = r_fault;

endmodule

// File: tb/tb_pedestrian_signal.sv
// Self-checking bench for pedestrian_signal: directed scenarios plus a
// randomized red-phase run against an elapsed-tick reference model.
module tb_pedestrian_signal;

   localparam int unsigned WALK_C  = 16;
   localparam int unsigned FLASH_C = 8;
   localparam int unsigned BLINK_C = 2;
`ifdef PED_CONFLICT_MONITOR_EN
   localparam logic MON = 1'b1;
`else
   localparam logic MON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic enable;
   logic red;
   logic yellow;
   logic green;
   logic ped_button;
   logic walk;
   logic dont_walk;
   logic req_pending;
   logic fault;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: mode 0=idle 1=walk 2=flash, ticks = enabled cycles spent in mode.
   int   m_mode;
   int   m_ticks;
   logic m_red_q;
   logic m_req;
   logic m_fault;

   always #5 clk = ~clk;

   pedestrian_signal #(
      .WALK_CYCLES (WALK_C),
      .FLASH_CYCLES(FLASH_C),
      .BLINK_HALF  (BLINK_C)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .red        (red),
      .yellow     (yellow),
      .green      (green),
      .ped_button (ped_button),
      .walk       (walk),
      .dont_walk  (dont_walk),
      .req_pending(req_pending),
      .fault      (fault)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_ticks = 0;
      m_red_q = 1'b0;
      m_req   = 1'b0;
      m_fault = 1'b0;
   endtask

   task automatic model_edge();
      logic rise, go, abort, fnext;
      rise  = red & ~m_red_q;
      fnext = m_fault;
      abort = (m_mode != 0) && !red;
      if (MON) begin
         if (red && green) fnext = 1'b1;
         if ((m_mode != 0) && (green || yellow)) begin
            abort = 1'b1;
            fnext = 1'b1;
         end
      end
      go = (m_mode == 0) && enable && rise && (m_req || ped_button) && !fnext;
      if (abort) begin
         m_mode = 0;
      end else if (m_mode == 1 && enable) begin
         m_ticks++;
         if (m_ticks == int'(WALK_C)) begin
            m_mode  = 2;
            m_ticks = 0;
         end
      end else if (m_mode == 2 && enable) begin
         m_ticks++;
         if (m_ticks == int'(FLASH_C)) m_mode = 0;
      end else if (go) begin
         m_mode  = 1;
         m_ticks = 0;
      end
      m_req   = go ? 1'b0 : (m_req | ped_button);
      m_red_q = red;
      m_fault = fnext;
   endtask

   task automatic check_all();
      logic exp_dw;
      if (m_mode == 0)      exp_dw = 1'b1;
      else if (m_mode == 2) exp_dw = ((m_ticks / int'(BLINK_C)) % 2) == 0;
      else                  exp_dw = 1'b0;
      check("walk", 32'(walk), 32'(m_mode == 1));
      check("dont_walk", 32'(dont_walk), 32'(exp_dw));
      check("req_pending", 32'(req_pending), 32'(m_req));
      check("fault", 32'(fault), 32'(m_fault));
      check("exclusive", 32'(walk & dont_walk), 32'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int         len;
      logic [7:0] pat;

      reset_n = 1'b0; enable = 1'b1; red = 1'b0; yellow = 1'b0; green = 1'b0; ped_button = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_walk", 32'(walk), 32'd0);
      check("rst_dont_walk", 32'(dont_walk), 32'd1);
      check("rst_req", 32'(req_pending), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      reset_n = 1'b1;
      repeat (3) cyc();

      // Nominal cycle: press, red rises, walk 16, flash 8 with blink pattern.
      ped_button = 1'b1; cyc();
      ped_button = 1'b0;
      check("req_latched", 32'(req_pending), 32'd1);
      red = 1'b1; cyc();
      check("req_cleared_at_walk", 32'(req_pending), 32'd0);
      len = 0;
      while (walk && len < 100) begin
         len++;
         cyc();
      end
      check("walk_len", 32'(len), 32'd16);
      for (int i = 0; i < 8; i++) begin
         pat[7-i] = dont_walk;
         cyc();
      end
      check("flash_pattern", 32'(pat), 32'h0000_00CC);
      check("back_idle_dw", 32'(dont_walk), 32'd1);
      repeat (3) cyc();
      red = 1'b0; repeat (4) cyc();

      // Red rises with no request: nothing happens.
      red = 1'b1;
      for (int i = 0; i < 30; i++) cyc();
      check("no_req_walk", 32'(walk), 32'd0);
      red = 1'b0; repeat (4) cyc();

      // Enable stall mid-walk stretches the walk by the stall length.
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; red = 1'b1; cyc();
      len = 0;
      while (walk && len < 200) begin
         if (len == 6)  enable = 1'b0;
         if (len == 16) enable = 1'b1;
         len++;
         cyc();
      end
      check("stall_walk_len", 32'(len), 32'd26);
      repeat (10) cyc();
      red = 1'b0; repeat (4) cyc();

      // Red drops during walk; a press in walk stays pending.
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; red = 1'b1; cyc();
      cyc();
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; cyc();
      check("walk_before_abort", 32'(walk), 32'd1);
      red = 1'b0; cyc();
      check("abort_walk", 32'(walk), 32'd0);
      check("abort_dont_walk", 32'(dont_walk), 32'd1);
      check("abort_req_kept", 32'(req_pending), 32'd1);
      repeat (3) cyc();

      // Randomized red phases, enable gaps and presses.
      for (int ph = 0; ph < 40; ph++) begin
         int hi, lo;
         hi = int'($urandom_range(10, 40));
         lo = int'($urandom_range(2, 10));
         for (int k = 0; k < hi + lo; k++) begin
            red        = (k < hi);
            enable     = ($urandom_range(0, 9) != 0);
            ped_button = ($urandom_range(0, 11) == 0);
            cyc();
         end
      end
      enable = 1'b1; ped_button = 1'b0; red = 1'b0;
      repeat (4) cyc();

      // Green during walk: conflict abort when monitored, ignored otherwise.
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; red = 1'b1; cyc();
      repeat (3) cyc();
      green = 1'b1; cyc();
      green = 1'b0;
      check("conflict_fault", 32'(fault), 32'(MON));
      check("conflict_walk", 32'(walk), 32'(!MON));
      repeat (30) cyc();
      red = 1'b0; repeat (4) cyc();
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; red = 1'b1; cyc();
      check("post_conflict_walk", 32'(walk), 32'(!MON));
      check("post_conflict_fault", 32'(fault), 32'(MON));
      repeat (30) cyc();
      red = 1'b0; repeat (4) cyc();

      // Asynchronous reset mid-flash, then a press is needed again.
      ped_button = 1'b1; cyc();
      ped_button = 1'b0; red = 1'b1; cyc();
      repeat (19) cyc();
      ped_button = 1'b1; cyc();
      ped_button = 1'b0;
      if (MON) check("pre_reset_idle", 32'(walk), 32'd0);
      else     check("pre_reset_flash", 32'(m_mode), 32'd2);
      #3 reset_n = 1'b0;
      #1;
      check("async_walk", 32'(walk), 32'd0);
      check("async_dont_walk", 32'(dont_walk), 32'd1);
      check("async_req", 32'(req_pending), 32'd0);
      check("async_fault", 32'(fault), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (10) cyc();
      check("post_reset_no_walk", 32'(walk), 32'd0);
      red = 1'b0; repeat (4) cyc();
      red = 1'b1; repeat (10) cyc();
      check("new_rise_no_press", 32'(walk), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pedestrian_signal.md
PEDESTRIAN_SIGNAL -- requirements
Module: pedestrian_signal

Interface
REQ-001 Parameter WALK_CYCLES, default 16, sets the WALK duration in enabled cycles (1..255).
REQ-002 Parameter FLASH_CYCLES, default 8, sets the flashing DONT_WALK duration in enabled cycles (1..255).
REQ-003 Parameter BLINK_HALF, default 2, sets the enabled cycles per blink half-period (1..255).
REQ-004 The port list SHALL be: clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  tick qualifier, the same enable that paces the vehicle signal controller.
REQ-007 red, yellow, green  in  1 each  vehicle lamp outputs from the traffic_light stage.
REQ-008 ped_button  in  1  pedestrian request, level, sampled every clk.
REQ-009 walk  out  1  WALK lamp, registered.
REQ-010 dont_walk  out  1  DONT_WALK lamp, registered.
REQ-011 req_pending  out  1  latched request indicator, registered.
REQ-012 fault  out  1  sticky conflict flag, registered (see Configuration).

Function
REQ-013 The block SHALL register red into red_q every clk; red_rise = red & ~red_q.
REQ-014 The FSM SHALL have the states IDLE, WALK and FLASH; all counters SHALL be 8-bit unsigned.
REQ-015 req_pending SHALL set on any clk with ped_button=1; it SHALL clear on IDLE->WALK, and clearing SHALL win over a simultaneous press.
REQ-016 A press during WALK or FLASH SHALL set req_pending for the next red phase.
REQ-017 IDLE->WALK SHALL occur when enable=1 & red_rise & (req_pending | ped_button); the counter loads WALK_CYCLES-1.
REQ-018 A red_rise with enable=0, or with no request, SHALL be ignored; the block waits for the next red_rise.
REQ-019 In WALK with enable=1: counter==0 -> FLASH, counter loads FLASH_CYCLES-1, blink counter loads BLINK_HALF-1, blink phase=1; otherwise the counter decrements.
REQ-020 In FLASH with enable=1: the blink counter decrements; at 0 it reloads BLINK_HALF-1 and the blink phase toggles. The main counter==0 -> IDLE.
REQ-021 red=0 in any clk while in WALK or FLASH SHALL force IDLE on that edge, regardless of enable or counter values.
REQ-022 With enable=0, state and all counters SHALL hold; red_q and req_pending still update.
REQ-023 Outputs SHALL be registered from next-state: IDLE walk=0 dont_walk=1; WALK walk=1 dont_walk=0; FLASH walk=0 dont_walk=blink phase.
REQ-024 walk and dont_walk SHALL never both be 1.

Reset
REQ-025 reset_n=0 SHALL immediately force state=IDLE, walk=0, dont_walk=1, req_pending=0, fault=0, red_q=0 and all counters=0.
REQ-026 A reset mid-WALK or mid-FLASH SHALL discard the pending request; after release the block SHALL need a new press and a new red_rise.

Configuration
REQ-027 Macro PED_CONFLICT_MONITOR_EN defined: in WALK or FLASH, green|yellow=1 SHALL force IDLE and set fault; red&green=1 in any state SHALL set fault.
REQ-028 With fault=1, IDLE->WALK SHALL be inhibited and dont_walk held at 1 until reset; req_pending still latches.
REQ-029 Macro undefined: fault SHALL be constant 0, no lockout; only REQ-021 aborts WALK.

Verification
REQ-030 Defaults, enable=1, press, then red rises -> walk=1 for 16 cycles, dont_walk toggles every 2 cycles for 8 cycles (1,1,0,0,1,1,0,0), then IDLE; req_pending cleared at WALK entry.
REQ-031 red rises with no press -> walk stays 0, dont_walk=1 for the whole red phase.
REQ-032 Enter WALK, enable=0 for 10 cycles at count 5 -> walk held at 1, total walk length = 16 enabled cycles + 10.
REQ-033 red drops at WALK cycle 4 -> walk=0, dont_walk=1 on the next edge; a press during WALK leaves req_pending=1 afterwards.
REQ-034 With PED_CONFLICT_MONITOR_EN: green=1 during WALK -> fault=1, IDLE; next red_rise with a request gives no WALK. Without the macro, fault stays 0.
REQ-035 reset_n pulsed low mid-FLASH -> outputs go to walk=0, dont_walk=1, req_pending=0 asynchronously, before the next clk edge.
